// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit, 4-bit-opcode CPU.
// Opcodes, condition codes, fetch FSM encoding and field positions.
package cpu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_LUI  = 4'h9;
    localparam logic [3:0] OP_LW   = 4'hA;
    localparam logic [3:0] OP_SW   = 4'hB;
    localparam logic [3:0] OP_BR   = 4'hC;
    localparam logic [3:0] OP_JAL  = 4'hD;
    localparam logic [3:0] OP_JR   = 4'hE;
    localparam logic [3:0] OP_EXEC = 4'hF;

    localparam logic [2:0] COND_NV  = 3'd0;
    localparam logic [2:0] COND_EQ  = 3'd1;
    localparam logic [2:0] COND_NE  = 3'd2;
    localparam logic [2:0] COND_LT  = 3'd3;
    localparam logic [2:0] COND_GE  = 3'd4;
    localparam logic [2:0] COND_LTU = 3'd5;
    localparam logic [2:0] COND_GEU = 3'd6;
    localparam logic [2:0] COND_AL  = 3'd7;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_RST    = 2'd0;
    localparam fetch_state_t ST_FETCH  = 2'd1;
    localparam fetch_state_t ST_BUFFER = 2'd2;

    localparam logic [15:0] BUBBLE_INSTR = 16'h0000;

    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int COND_MSB = 11;
    localparam int COND_LSB = 9;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch and imem.
// The fetch stage is the master; ready qualifies rdata for the live request.
interface fetch_unit_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer for the fetch stage.
// Clear beats load beats drain so a redirect always empties it.
module fetch_skid_buf #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         drain,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full
);

    logic [W-1:0] data_q;
    logic         full_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else if (clear) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else if (load) begin
            data_q <= din;
            full_q <= 1'b1;
        end else if (drain) begin
            full_q <= 1'b0;
        end
    end

    assign dout = data_q;
    assign full = full_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, fetch FSM and the IF/ID register.
// Stalls park one returned word in a skid buffer; redirects flush.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              ADDR_W   = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_unit_if.master       imem,
    input  logic               stall,
    input  logic               redirect_en,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [3:0]         if_opcode,
    output logic [2:0]         if_cond,
    output logic [ADDR_W-1:0]  if_pc_plus1
);

    fetch_state_t       state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_inc;
    logic               ifv;
    logic [INSTR_W-1:0] ifi;
    logic [ADDR_W-1:0]  ifpp1;

    logic               st_rst;
    logic               st_fetch;
    logic               st_buf;
    logic               do_redir;
    logic               do_take;
    logic               do_skid;
    logic               do_bubble;
    logic               do_drain;

    logic [INSTR_W-1:0] skid_data;
    logic               skid_full;

    assign st_rst   = (state == ST_RST);
    assign st_fetch = (state == ST_FETCH);
    assign st_buf   = (state == ST_BUFFER);
    assign pc_inc   = pc + ADDR_W'(1);

    // Mutually exclusive actions; redirect masks everything past RST.
    assign do_redir  = !st_rst && redirect_en;
    assign do_take   = st_fetch && !redirect_en
                     && imem.imem_ready && !stall;
    assign do_skid   = st_fetch && !redirect_en
                     && imem.imem_ready && stall;
    assign do_bubble = st_fetch && !redirect_en
                     && !imem.imem_ready && !stall;
    assign do_drain  = st_buf && !redirect_en
                     && !stall && skid_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RST;
            pc    <= RESET_PC;
            ifv   <= 1'b0;
            ifi   <= INSTR_W'(BUBBLE_INSTR);
            ifpp1 <= RESET_PC;
        end else begin
            unique case (1'b1)
                st_rst: begin
                    state <= ST_FETCH;
                end
                do_redir: begin
                    state <= ST_FETCH;
                    pc    <= redirect_pc;
                    ifv   <= 1'b0;
                    ifi   <= INSTR_W'(BUBBLE_INSTR);
                end
                do_take: begin
                    pc    <= pc_inc;
                    ifv   <= 1'b1;
                    ifi   <= imem.imem_rdata;
                    ifpp1 <= pc_inc;
                end
                do_skid: begin
                    state <= ST_BUFFER;
                    pc    <= pc_inc;
                end
                do_bubble: begin
                    ifv   <= 1'b0;
                    ifi   <= INSTR_W'(BUBBLE_INSTR);
                end
                // pc already points past the parked word
                do_drain: begin
                    state <= ST_FETCH;
                    ifv   <= 1'b1;
                    ifi   <= skid_data;
                    ifpp1 <= pc;
                end
                default: begin
                end
            endcase
        end
    end

    fetch_skid_buf #(
        .W (INSTR_W)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (do_skid),
        .drain (do_drain),
        .clear (do_redir),
        .din   (imem.imem_rdata),
        .dout  (skid_data),
        .full  (skid_full)
    );

    assign imem.imem_req  = st_fetch;
    assign imem.imem_addr = pc;

    assign if_valid    = ifv;
    assign if_instr    = ifi;
    assign if_opcode   = ifi[OPC_MSB:OPC_LSB];
    assign if_cond     = ifi[COND_MSB:COND_LSB];
    assign if_pc_plus1 = ifpp1;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 16-bit, 4-bit-opcode CPU. Owns the program counter and issues word-addressed requests to instruction memory. Captures each returned instruction in the IF/ID pipeline register. That register drives the opcode and condition fields consumed by the control decoder. Handles hazard stalls through a one-entry skid buffer, and branch/JAL/JR redirects by flushing.

## Interface
Parameters:
- ADDR_W, 16, PC and instruction-memory address width (word addressed)
- INSTR_W, 16, instruction width
- RESET_PC, 16'h0000, PC value loaded on reset

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset; asynchronous and active-low
- imem_req  output  1  fetch request valid
- imem_addr  output  ADDR_W  fetch address (current PC)
- imem_ready  input  1  imem_rdata valid this cycle for the current request
- imem_rdata  input  INSTR_W  returned instruction
- stall  input  1  hazard unit: hold IF/ID contents
- redirect_en  input  1  taken branch, JAL or JR resolved
- redirect_pc  input  ADDR_W  new fetch target
- if_valid  output  1  IF/ID holds a real instruction
- if_instr  output  INSTR_W  IF/ID instruction
- if_opcode  output  4  if_instr[15:12], to control OpCode
- if_cond  output  3  if_instr[11:9], to control Cond
- if_pc_plus1  output  ADDR_W  address of captured instruction + 1 (JAL link value)

## Operation
- States: RST, FETCH, BUFFER.
  - RST is the single cycle after reset release.
  - No request is issued in RST.
  - RST always goes to FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - On imem_ready with stall=0: IF/ID loads imem_rdata, if_valid=1, if_pc_plus1=pc+1, pc increments.
  - On imem_ready with stall=1: the instruction goes into the skid buffer, pc increments, next state is BUFFER.
  - Without imem_ready: imem_addr must stay stable. If stall=0, if_valid clears to 0 (bubble).
- BUFFER:
  - imem_req=0.
  - While stall=1, IF/ID and the buffer both hold.
  - When stall=0, IF/ID loads the buffered instruction (if_valid=1) and the state returns to FETCH.
- stall=1 freezes all if_* outputs. The PC still advances if a response is buffered.
- redirect_en has highest priority, in any state except RST:
  - pc<=redirect_pc and if_valid<=0, even while stall=1.
  - The skid buffer is cleared.
  - Any imem_rdata arriving in the redirect cycle is discarded.
  - Next state is FETCH.
- Arithmetic:
  - pc+1 is modulo 2^ADDR_W, so 16'hFFFF wraps to 16'h0000.
  - No byte addressing.
- Bubble encoding: if_instr=16'h0000 with if_valid=0. Consumers must gate on if_valid.

## Timing
- Reset values (asynchronous, rst_n low):
  - pc=RESET_PC, state=RST.
  - imem_req=0, imem_addr=RESET_PC.
  - if_valid=0, if_instr=0, if_opcode=0, if_cond=0.
  - if_pc_plus1=RESET_PC, skid buffer empty.
- Latency:
  - From the imem_ready edge to the if_valid/if_instr update: 1 cycle.
  - From redirect_en to a request at redirect_pc: 1 cycle.
  - From redirect to a new if_valid: 2 cycles minimum.
- Throughput: one instruction per cycle when imem_ready is continuously high and stall=0.
- Simultaneous events:
  - redirect_en with imem_ready: redirect wins and the data is dropped.
  - redirect_en with stall in BUFFER: the buffer is dropped and IF/ID is flushed.
  - stall dropping in the same cycle imem_ready is high while in FETCH: captured directly.
- Reset asserted mid-fetch abandons the request immediately. imem_req drops asynchronously.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants OP_ADD..OP_EXEC (4'h0..4'hF)
  - the condition-code constants
  - fetch_state_t (RST, FETCH, BUFFER)
  - BUBBLE_INSTR=16'h0000
  - field position constants OPC_MSB/LSB and COND_MSB/LSB
- One sub-module, fetch_skid_buf, holds the one-entry buffer: data plus full flag, with load, drain and clear inputs.
- The PC, FSM and IF/ID register stay in fetch_unit.

## Test plan
- Reset then streaming:
  - Stimulus: release rst_n, imem_ready=1, rdata=16'h0123,16'h1456,...
  - Response: imem_req=0 in cycle 0, addresses 0,1,2 from cycle 1, and if_instr matches 1 cycle after each ready, with if_pc_plus1=1,2,3.
- Wait states: imem_ready low for 3 cycles at pc=5 -> imem_addr stays 5, if_valid=0 for those cycles, no PC advance.
- Stall with skid:
  - Stimulus: stall=1 for 4 cycles while an instruction 16'hA0FF returns at pc=8.
  - Response: IF/ID holds the prior instruction, state BUFFER, imem_req=0, pc=9. On stall release if_instr=16'hA0FF, and the next request is at 9.
- Redirect:
  - Stimulus: redirect_en with redirect_pc=16'h0040 in the same cycle as imem_ready.
  - Response: data dropped, if_valid=0 next cycle, imem_addr=16'h0040 next cycle.
- Redirect during stall in BUFFER -> buffer cleared, if_valid=0, fetch resumes at redirect_pc.
- Wrap: pc=16'hFFFF fetched -> if_pc_plus1=16'h0000, next imem_addr=16'h0000.
